mc_control: RTL

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_decode.sv | 52 +++++
 rtl/mc_control.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM state codes,
// opcode/funct constants, ALU operation codes and instruction classes.
// Contents:
//   ctrlState_t  - FSM state encoding (IF=0 .. HALT=5)
//   aluOp_t      - ALU operation selected by the controller
//   instrClass_t - decoded instruction class driving the state sequence
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } ctrlState_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5
  } aluOp_t;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_ADDI,
    CLS_ORI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_HALT
  } instrClass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder for the multicycle controller.
// Maps the opcode (and funct for R-type) onto an instruction class and
// the ALU operation an R-type instruction needs in EXE.
// Ports:
//   op         - opcode field
//   funct      - funct field (meaningful only when op is R-type)
//   instrClass - decoded class; unknown op or funct decodes as CLS_NOP
//   rTypeAluOp - ALU operation for the R-type funct (ADD when unknown)
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output instrClass_t instrClass,
  output aluOp_t      rTypeAluOp
);

  // An R-type with an unrecognised funct must behave as a NOP, so the
  // funct match also decides whether op=0 is a real R-type.
  logic functKnown;

  always_comb begin
    functKnown = 1'b1;
    rTypeAluOp = ALU_ADD;
    case (funct)
      FN_ADD:  rTypeAluOp = ALU_ADD;
      FN_SUB:  rTypeAluOp = ALU_SUB;
      FN_AND:  rTypeAluOp = ALU_AND;
      FN_OR:   rTypeAluOp = ALU_OR;
      FN_SLT:  rTypeAluOp = ALU_SLT;
      FN_SLL:  rTypeAluOp = ALU_SLL;
      default: functKnown = 1'b0;
    endcase
  end

  always_comb begin
    instrClass = CLS_NOP;
    case (op)
      OP_RTYPE: instrClass = functKnown ? CLS_RTYPE : CLS_NOP;
      OP_ADDI:  instrClass = CLS_ADDI;
      OP_ORI:   instrClass = CLS_ORI;
      OP_LW:    instrClass = CLS_LW;
      OP_SW:    instrClass = CLS_SW;
      OP_BEQ:   instrClass = CLS_BEQ;
      OP_BNE:   instrClass = CLS_BNE;
      OP_J:     instrClass = CLS_J;
      OP_HALT:  instrClass = CLS_HALT;
      default:  instrClass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-style controller: IF/ID/EXE/MEM/WB/HALT state machine,
// datapath enables and selects, and a retired-instruction counter.
// Ports:
//   clk, Reset                         - clock, async active-high reset
//   op, funct                          - instruction register fields
//   zero, mem_ready                    - ALU zero flag, memory handshake
//   PCWrite/IRWrite/RegWrite/MemWrite/MemRead - write/read enables
//   IorD/ALUSrcA/RegDst/MemToReg       - 1-bit mux selects
//   ALUSrcB, PCSrc                     - 2-bit mux selects
//   ALUOp                              - ALU operation code
//   state, halted, icount              - FSM state, halt flag, retire count
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        IorD,
  output logic        ALUSrcA,
  output logic        RegDst,
  output logic        MemToReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUOp,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] icount
);

  ctrlState_t  state_q, state_d;
  logic [31:0] icount_q, icount_d;
  instrClass_t instrClass;
  aluOp_t      rTypeAluOp;
  logic        retire;

  mc_decode uDecode (
    .op         (op),
    .funct      (funct),
    .instrClass (instrClass),
    .rTypeAluOp (rTypeAluOp)
  );

  // State and retire counter registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IF;
      icount_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

  // Next-state logic; an instruction retires when control returns to IF
  // from a later state, or when it enters HALT.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (instrClass)
          CLS_RTYPE, CLS_ADDI, CLS_ORI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE:
                   state_d = S_EXE;
          CLS_HALT: state_d = S_HALT;
          default:  state_d = S_IF;
        endcase
      end
      S_EXE: begin
        case (instrClass)
          CLS_RTYPE, CLS_ADDI, CLS_ORI: state_d = S_WB;
          CLS_LW, CLS_SW:               state_d = S_MEM;
          default:                      state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (!mem_ready)               state_d = S_MEM;
        else if (instrClass == CLS_LW) state_d = S_WB;
        else                          state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    retire = ((state_q == S_ID) || (state_q == S_EXE) ||
              (state_q == S_MEM) || (state_q == S_WB)) &&
             ((state_d == S_IF) || (state_d == S_HALT));
    icount_d = retire ? icount_q + 32'd1 : icount_q;
  end

  // Output logic; everything not explicitly used in a state stays 0, and
  // Reset overrides all outputs so no access leaks out while it is held.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    ALUSrcB  = 2'd0;
    PCSrc    = 2'd0;
    ALUOp    = ALU_ADD;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'd1;
        end
      end
      S_ID: begin
        ALUSrcB = 2'd3;
        if (instrClass == CLS_J) begin
          PCWrite = 1'b1;
          PCSrc   = 2'd2;
        end
      end
      S_EXE: begin
        case (instrClass)
          CLS_RTYPE: begin
            ALUSrcA = 1'b1;
            ALUOp   = rTypeAluOp;
          end
          CLS_ADDI, CLS_LW, CLS_SW: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
          end
          CLS_ORI: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            ALUOp   = ALU_OR;
          end
          CLS_BEQ, CLS_BNE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_SUB;
            if ((instrClass == CLS_BEQ) == zero) begin
              PCWrite = 1'b1;
              PCSrc   = 2'd1;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        IorD = 1'b1;
        if (instrClass == CLS_LW) MemRead = 1'b1;
        if (instrClass == CLS_SW) MemWrite = mem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (instrClass == CLS_RTYPE);
        MemToReg = (instrClass == CLS_LW);
      end
      default: ;
    endcase
    if (Reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      IorD     = 1'b0;
      ALUSrcA  = 1'b0;
      RegDst   = 1'b0;
      MemToReg = 1'b0;
      ALUSrcB  = 2'd0;
      PCSrc    = 2'd0;
      ALUOp    = ALU_ADD;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == S_HALT);
  assign icount = icount_q;

endmodule
